// File: rtl/seq_divider_32.sv
// Sequential restoring divider, signed or unsigned, WIDTH-bit operands.
// One quotient bit is produced per cycle in RUN. FIX applies the signs,
// and DONE publishes registered results together with a one-cycle done pulse.
module seq_divider_32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DZ,
   output logic             OF,
   output logic             ZF,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (raw A on divide-by-zero)
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             of_q, of_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic             dz_out_q, dz_out_d;
   logic             of_out_q, of_out_d;
   logic             zf_out_q, zf_out_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, trial;

   // Operand magnitudes and the restoring trial subtraction at WIDTH+1 bits.
   // Negating the most-negative value yields 2^(WIDTH-1) read as unsigned.
   always_comb begin
      a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
      b_mag  = (sgn && B[WIDTH-1]) ? -B : B;
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr_q};
   end

   // Next-state and datapath updates for the IDLE/RUN/FIX/DONE sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      of_d     = of_q;
      q_out_d  = q_out_q;
      r_out_d  = r_out_q;
      dz_out_d = dz_out_q;
      of_out_d = of_out_q;
      zf_out_d = zf_out_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               dz_d   = (B == '0);
               of_d   = sgn && (A == MIN_V) && (B == '1);
               qneg_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
               rneg_d = sgn && A[WIDTH-1];
               dvsr_d = b_mag;
               cnt_d  = '0;
               if (B == '0) begin
                  rem_d   = A;
                  quo_d   = '0;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = a_mag;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (qneg_q) quo_d = -quo_q;
            if (rneg_q) rem_d = -rem_q;
            state_d = DONE;
         end
         DONE: begin
            q_out_d  = dz_q ? '1 : quo_q;
            r_out_d  = rem_q;
            dz_out_d = dz_q;
            of_out_d = of_q;
            zf_out_d = (q_out_d == '0);
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset wins over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         of_q     <= 1'b0;
         q_out_q  <= '0;
         r_out_q  <= '0;
         dz_out_q <= 1'b0;
         of_out_q <= 1'b0;
         zf_out_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         of_q     <= of_d;
         q_out_q  <= q_out_d;
         r_out_q  <= r_out_d;
         dz_out_q <= dz_out_d;
         of_out_q <= of_out_d;
         zf_out_q <= zf_out_d;
         done_q   <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign Q         = q_out_q;
   assign R         = r_out_q;
   assign DZ        = dz_out_q;
   assign OF        = of_out_q;
   assign ZF        = zf_out_q;
   assign state_dbg = state_q;

endmodule
